// File: rtl/fcpu_pkg.sv
// Shared CDB definitions: field widths and the packed {tag, data} record.
// The tag/data offsets are common to the arbiter, reservation stations and ROB.
package fcpu_pkg;

  localparam int RSV_ID_W = 6;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
  } cdb_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO for the CDB arbiter.
// Pointers carry a wrap bit so full and empty are distinguishable without a counter.
module cdb_src_fifo
  import fcpu_pkg::*;
#(
  parameter int  DEPTH_W = 2,
  parameter type entry_t = cdb_t
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  input  logic   flush_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int PTR_W = DEPTH_W + 1;

  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  entry_t           mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[DEPTH_W] != rd_q[DEPTH_W]) &&
                   (wr_q[DEPTH_W-1:0] == rd_q[DEPTH_W-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[DEPTH_W-1:0]];

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[DEPTH_W-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers N_SOURCES FU result streams and broadcasts one per cycle, round-robin.
// Optional `CDB_BYPASS_EN lets a winner with an empty FIFO skip it (1-cycle latency).
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter  int N_SOURCES    = 4,
  parameter  int FIFO_DEPTH_W = 2,
  localparam int SRC_W        = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [N_SOURCES-1:0]         src_valid,
  input  logic [N_SOURCES*RSV_ID_W-1:0] src_tag,
  input  logic [N_SOURCES*DATA_W-1:0]  src_data,
  output logic [N_SOURCES-1:0]         src_ready,
  input  logic                         i_flush,
  output logic                         cdb_valid,
  output logic [CDB_W-1:0]             cdb,
  output logic [SRC_W-1:0]             cdb_src
);

  cdb_t                 src_ent [N_SOURCES];
  cdb_t                 head    [N_SOURCES];
  logic [N_SOURCES-1:0] full;
  logic [N_SOURCES-1:0] empty;
  logic [N_SOURCES-1:0] accept;
  logic [N_SOURCES-1:0] req;
  logic [N_SOURCES-1:0] grant;
  logic [N_SOURCES-1:0] push;
  logic [N_SOURCES-1:0] pop;

  logic                 ready_en_q;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]     gnt_idx;
  logic                 any_gnt;
  logic                 cdb_valid_q, cdb_valid_d;
  cdb_t                 cdb_q, cdb_d;
  logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;

  for (genvar i = 0; i < N_SOURCES; i++) begin : g_src
    assign src_ent[i].tag  = src_tag[i*RSV_ID_W +: RSV_ID_W];
    assign src_ent[i].data = src_data[i*DATA_W +: DATA_W];

    // Ready depends only on registered state, so a same-cycle pop never frees a slot.
    assign src_ready[i] = ready_en_q && !full[i];
    assign accept[i]    = src_valid[i] && src_ready[i];

`ifdef CDB_BYPASS_EN
    assign req[i]  = !empty[i] || accept[i];
    assign push[i] = accept[i] && !i_flush && !(grant[i] && empty[i]);
`else
    assign req[i]  = !empty[i];
    assign push[i] = accept[i] && !i_flush;
`endif
    assign pop[i]  = grant[i] && !empty[i] && !i_flush;

    cdb_src_fifo #(
      .DEPTH_W (FIFO_DEPTH_W),
      .entry_t (cdb_t)
    ) u_fifo (
      .clk         (clk),
      .nrst        (nrst),
      .push_i      (push[i]),
      .push_data_i (src_ent[i]),
      .pop_i       (pop[i]),
      .flush_i     (i_flush),
      .full_o      (full[i]),
      .empty_o     (empty[i]),
      .head_o      (head[i])
    );
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int               idx;
    logic [SRC_W-1:0] sel;
    grant   = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N_SOURCES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_SOURCES) idx = idx - N_SOURCES;
      sel = SRC_W'(idx);
      if (!any_gnt && req[sel]) begin
        any_gnt    = 1'b1;
        gnt_idx    = sel;
        grant[sel] = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_d       = cdb_q;
    cdb_src_d   = cdb_src_q;
    if (any_gnt && !i_flush) begin
      cdb_valid_d = 1'b1;
      cdb_src_d   = gnt_idx;
      rr_ptr_d    = (gnt_idx == SRC_W'(N_SOURCES-1)) ? '0 : gnt_idx + SRC_W'(1);
`ifdef CDB_BYPASS_EN
      cdb_d       = empty[gnt_idx] ? src_ent[gnt_idx] : head[gnt_idx];
`else
      cdb_d       = head[gnt_idx];
`endif
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_en_q  <= 1'b0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
      cdb_src_q   <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb       = cdb_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: per-source scoreboard plus directed latency,
// round-robin, backpressure, flush, async-reset and pointer-wrap sequences.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*RSV_ID_W-1:0] src_tag = '0;
  logic [NS*DATA_W-1:0]   src_data = '0;
  logic [NS-1:0]     src_ready;
  logic              i_flush = 1'b0;
  logic              cdb_valid;
  logic [CDB_W-1:0]  cdb;
  logic [1:0]        cdb_src;

  cdb_arbiter #(.N_SOURCES(NS), .FIFO_DEPTH_W(2)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .i_flush   (i_flush),
    .cdb_valid (cdb_valid),
    .cdb       (cdb),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   gseq = 0;
  int   seen [NS];
  cdb_t cur [NS];
  cdb_t exp_q [NS][$];
  cdb_t mon_e;

  typedef struct {
    int               src;
    logic [RSV_ID_W-1:0] tag;
    logic [DATA_W-1:0]   data;
    logic [1:0]       exp_src;
    logic [CDB_W-1:0] exp_cdb;
  } vec_t;
  vec_t vec [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cdb_t gen(input int i);
    cdb_t e;
    gseq++;
    e.tag  = RSV_ID_W'(gseq);
    e.data = DATA_W'((i << 24) | gseq);
    return e;
  endfunction

  function automatic int sb_pending();
    int n = 0;
    for (int i = 0; i < NS; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Scoreboard consumer: every broadcast must be the oldest pending result of its source.
  always @(negedge clk) begin
    if (nrst === 1'b1 && cdb_valid === 1'b1) begin
      checks++;
      seen[cdb_src]++;
      if (exp_q[cdb_src].size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got src=%0d cdb=%0h expected no output", cdb_src, cdb);
      end else begin
        mon_e = exp_q[cdb_src].pop_front();
        if (cdb !== mon_e) begin
          failures++;
          $display("FAIL sb_order: src=%0d got %0h expected %0h", cdb_src, cdb, mon_e);
        end
      end
    end
  end

  // Drive one cycle of stimulus from posedge+1, record accepts at the edge, return at posedge+1.
  task automatic cycle(input logic [NS-1:0] v, input logic fl);
    logic [NS-1:0] acc;
    for (int i = 0; i < NS; i++) begin
      src_tag[i*RSV_ID_W +: RSV_ID_W] = cur[i].tag;
      src_data[i*DATA_W +: DATA_W]    = cur[i].data;
    end
    src_valid = v;
    i_flush   = fl;
    acc       = v & src_ready;
    @(posedge clk);
    for (int i = 0; i < NS; i++) begin
      if (fl) exp_q[i].delete();
      else if (acc[i]) begin
        exp_q[i].push_back(cur[i]);
        cur[i] = gen(i);
      end
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    src_valid = '0;
    i_flush   = 1'b0;
    while (sb_pending() > 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(sb_pending()), 64'd0);
  endtask

  task automatic do_reset();
    src_valid = '0;
    i_flush   = 1'b0;
    nrst      = 1'b0;
    #3;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    for (int i = 0; i < NS; i++) exp_q[i].delete();
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_src_ready", 64'(src_ready), 64'hF);
    chk("rel_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rel_cdb",       64'(cdb),       64'd0);
    chk("rel_cdb_src",   64'(cdb_src),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] t3_exp;
    int         s3;
    for (int i = 0; i < NS; i++) begin
      seen[i] = 0;
      cur[i]  = gen(i);
    end
    vec[0] = '{src: 0, tag: 6'd3,  data: 32'hDEAD_BEEF, exp_src: 2'd0, exp_cdb: 38'h03_DEAD_BEEF};
    vec[1] = '{src: 1, tag: 6'd0,  data: 32'h0000_0000, exp_src: 2'd1, exp_cdb: 38'h00_0000_0000};
    vec[2] = '{src: 3, tag: 6'd63, data: 32'hFFFF_FFFF, exp_src: 2'd3, exp_cdb: 38'h3F_FFFF_FFFF};
    vec[3] = '{src: 2, tag: 6'd21, data: 32'h1234_5678, exp_src: 2'd2, exp_cdb: 38'h15_1234_5678};

    #1;
    @(posedge clk);
    #1;
    do_reset();

    // Single-result latency from each source, output lasts one cycle.
    for (int k = 0; k < 4; k++) begin
      cur[vec[k].src].tag  = vec[k].tag;
      cur[vec[k].src].data = vec[k].data;
      cycle(NS'(1 << vec[k].src), 1'b0);
`ifndef CDB_BYPASS_EN
      chk("t1_not_early", 64'(cdb_valid), 64'd0);
      cycle('0, 1'b0);
`endif
      chk("t1_valid", 64'(cdb_valid), 64'd1);
      chk("t1_cdb",   64'(cdb),       64'(vec[k].exp_cdb));
      chk("t1_src",   64'(cdb_src),   64'(vec[k].exp_src));
      cycle('0, 1'b0);
      chk("t1_one_cycle", 64'(cdb_valid), 64'd0);
    end
    drain(10);

    // All four sources saturating: strict 0,1,2,3 rotation with no idle cycles.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle(4'hF, 1'b0);
`ifdef CDB_BYPASS_EN
      chk("t2_valid", 64'(cdb_valid), 64'd1);
      chk("t2_src",   64'(cdb_src),   64'(c % 4));
`else
      if (c == 0) chk("t2_first_idle", 64'(cdb_valid), 64'd0);
      else begin
        chk("t2_valid", 64'(cdb_valid), 64'd1);
        chk("t2_src",   64'(cdb_src),   64'((c - 1) % 4));
      end
`endif
    end
    drain(40);

    // src2 back-to-back against src0/src1 load: ready[2] drops once its FIFO fills.
    do_reset();
`ifdef CDB_BYPASS_EN
    t3_exp = 6'b101111;
`else
    t3_exp = 6'b001111;
`endif
    for (int c = 0; c < 8; c++) begin
      cycle(4'b0111, 1'b0);
      if (c < 6) chk("t3_ready2", 64'(src_ready[2]), 64'(t3_exp[c]));
    end
    drain(40);

    // Flush discards queued results and a same-cycle candidate; rr_ptr is not disturbed.
    do_reset();
    cycle(4'b0111, 1'b0);
    cycle(4'b1000, 1'b1);
    chk("t4_flush_valid", 64'(cdb_valid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      cycle('0, 1'b0);
      chk("t4_quiet", 64'(cdb_valid), 64'd0);
    end
    cycle(4'b1001, 1'b0);
`ifdef CDB_BYPASS_EN
    chk("t4_post_valid", 64'(cdb_valid), 64'd1);
    chk("t4_post_src",   64'(cdb_src),   64'd3);
    cycle('0, 1'b0);
    chk("t4_post2_src",  64'(cdb_src),   64'd0);
`else
    chk("t4_post_lat",   64'(cdb_valid), 64'd0);
    cycle('0, 1'b0);
    chk("t4_post_valid", 64'(cdb_valid), 64'd1);
    chk("t4_post_src",   64'(cdb_src),   64'd0);
    cycle('0, 1'b0);
    chk("t4_post2_src",  64'(cdb_src),   64'd3);
`endif
    drain(10);

    // Async reset in the middle of a burst.
    for (int c = 0; c < 4; c++) cycle(4'hF, 1'b0);
    chk("t5_burst_valid", 64'(cdb_valid), 64'd1);
    do_reset();
    cycle(4'hF, 1'b0);
`ifndef CDB_BYPASS_EN
    cycle('0, 1'b0);
`endif
    chk("t5_rr_reset_src", 64'(cdb_src), 64'd0);
    drain(40);

    // Ten results through one source: pointers wrap, ready never drops.
    s3 = seen[3];
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1000, 1'b0);
      chk("t6_ready3", 64'(src_ready[3]), 64'd1);
    end
    drain(20);
    chk("t6_count", 64'(seen[3] - s3), 64'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
